// File: rtl/reductor_saturado_pkg.sv
// Shared widths and constants for the wide-to-narrow rounding/saturating reducer.
package reductor_saturado_pkg;

  localparam int N_DEF = 25;
  localparam int F_DEF = 15;

  localparam logic signed [N_DEF-1:0] MAX_POS = {1'b0, {(N_DEF-1){1'b1}}};
  localparam logic signed [N_DEF-1:0] MIN_NEG = {1'b1, {(N_DEF-1){1'b0}}};

  // Half of one output LSB, expressed in input LSBs, in the widened sum width.
  localparam logic [2*N_DEF:0] RND_CONST = (2*N_DEF+1)'(1) << (F_DEF-1);

  typedef logic signed [2*N_DEF-1:0] valor_ext_t;
  typedef logic signed [N_DEF-1:0]   valor_red_t;

endpackage

// File: rtl/reductor_saturado_if.sv
// Streaming handshake bundle: wide word in, narrow word out, valid/ready on each side.
interface reductor_saturado_if
  import reductor_saturado_pkg::*;
#(
  parameter int N = N_DEF
) ();

  logic signed [2*N-1:0] ValorExt;
  logic                  in_valid;
  logic                  in_ready;
  logic signed [N-1:0]   ValorRed;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output ValorExt, in_valid, out_ready,
    input  in_ready, ValorRed, out_valid
  );

  modport slave (
    input  ValorExt, in_valid, out_ready,
    output in_ready, ValorRed, out_valid
  );

endinterface

// File: rtl/reductor_saturado_redondeo_sat.sv
// Combinational half-up rounding of a Q(2F) word down to Q(F), saturated to N bits.
module redondeo_sat
  import reductor_saturado_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int F = F_DEF
) (
  input  logic signed [2*N-1:0] valor_ext,
  output logic signed [N-1:0]   valor_red,
  output logic                  sat
);

  localparam logic signed [2*N:0] RND = (2*N+1)'(1) << (F-1);

  // One extra bit of headroom so adding the rounding constant never wraps.
  function automatic logic signed [2*N:0] round_half_up(input logic signed [2*N-1:0] x);
    return $signed({x[2*N-1], x}) + RND;
  endfunction

  // The shifted value fits in N bits when every bit from N-1 upward matches the sign.
  function automatic logic fits_n(input logic signed [2*N:0] c);
    logic [N+1:0] upper;
    upper = c[2*N:N-1];
    return (&upper) || !(|upper);
  endfunction

  function automatic logic signed [N-1:0] saturate(input logic neg);
    return neg ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  endfunction

  logic signed [2*N:0] sum_c;
  logic signed [2*N:0] cand_c;

  // Round, drop the extra fraction bits, then clamp if the result overflows N bits.
  always_comb begin
    sum_c     = round_half_up(valor_ext);
    cand_c    = sum_c >>> F;
    sat       = !fits_n(cand_c);
    valor_red = sat ? saturate(sum_c[2*N]) : cand_c[N-1:0];
  end

endmodule

// File: rtl/reductor_saturado.sv
// Two-stage reducer: S1 captures the wide word, S2 holds the rounded/saturated result.
// A single stall enable freezes both stages whenever the output is held.
module reductor_saturado
  import reductor_saturado_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int F = F_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  reductor_saturado_if.slave    bus,
  input  logic                  clr_stats,
  output logic                  sat_flag,
  output logic [15:0]           sat_count
);

  logic                  en;
  logic                  vld_p1_q, vld_p1_d;
  logic signed [2*N-1:0] data_p1_q, data_p1_d;
  logic                  vld_p2_q, vld_p2_d;
  logic signed [N-1:0]   red_p2_q, red_p2_d;
  logic                  sat_flag_q, sat_flag_d;
  logic [15:0]           sat_count_q, sat_count_d;
  logic signed [N-1:0]   red_c;
  logic                  sat_c;
  logic                  sat_load;

  // ---- S1 -> S2 boundary: rounding and saturation ----
  redondeo_sat #(.N(N), .F(F)) u_redondeo_sat (
    .valor_ext (data_p1_q),
    .valor_red (red_c),
    .sat       (sat_c)
  );

  // Next-state for both pipeline stages and the saturation statistics.
  always_comb begin
    en          = !vld_p2_q || bus.out_ready;
    vld_p1_d    = vld_p1_q;
    data_p1_d   = data_p1_q;
    vld_p2_d    = vld_p2_q;
    red_p2_d    = red_p2_q;
    sat_flag_d  = sat_flag_q;
    sat_count_d = sat_count_q;
    sat_load    = en && vld_p1_q && sat_c;

    if (en) begin
      vld_p1_d = bus.in_valid;
      vld_p2_d = vld_p1_q;
      if (bus.in_valid) data_p1_d = bus.ValorExt;
      if (vld_p1_q)     red_p2_d  = red_c;
    end

    // Clear wins over a coincident saturated load; the counter sticks at all-ones.
    if (clr_stats) begin
      sat_flag_d  = 1'b0;
      sat_count_d = 16'd0;
    end else if (sat_load) begin
      sat_flag_d = 1'b1;
      if (sat_count_q != 16'hFFFF) sat_count_d = sat_count_q + 16'd1;
    end
  end

  // ---- S1 / S2 control, output word and statistics (async reset) ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      red_p2_q    <= '0;
      sat_flag_q  <= 1'b0;
      sat_count_q <= 16'd0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      red_p2_q    <= red_p2_d;
      sat_flag_q  <= sat_flag_d;
      sat_count_q <= sat_count_d;
    end
  end

  // ---- S1 data capture (qualified by vld_p1_q, so no reset needed) ----
  always_ff @(posedge clk) begin
    data_p1_q <= data_p1_d;
  end

  assign bus.in_ready  = en;
  assign bus.ValorRed  = red_p2_q;
  assign bus.out_valid = vld_p2_q;
  assign sat_flag      = sat_flag_q;
  assign sat_count     = sat_count_q;

endmodule

// File: tb/tb_reductor_saturado.sv
// Self-checking bench for reductor_saturado: directed vector table, stall/clear/reset
// sequences, and a randomized stream scored against an arithmetic reference model.
module tb_reductor_saturado;
  import reductor_saturado_pkg::*;

  localparam int N = N_DEF;
  localparam int F = F_DEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_stats;
  logic        sat_flag;
  logic [15:0] sat_count;

  always #5 clk = ~clk;

  reductor_saturado_if #(.N(N)) bus ();

  reductor_saturado #(.N(N), .F(F)) dut (
    .clk       (clk),
    .reset     (rst),
    .bus       (bus),
    .clr_stats (clr_stats),
    .sat_flag  (sat_flag),
    .sat_count (sat_count)
  );

  int total = 0;
  int bad   = 0;

  logic [N-1:0] exp_q[$];
  int           model_sat;

  logic         obs_vld, obs_rdy, obs_acc;
  logic [N-1:0] obs_red;

  typedef struct {
    logic [2*N-1:0] x;
    logic [N-1:0]   exp;
    logic [15:0]    cnt;
    logic           flag;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2*N-1:0] w(input longint v);
    return v[2*N-1:0];
  endfunction

  // Reference: real-valued x/2^(2F) rounded half-up to a multiple of 2^-F, then clamped.
  function automatic logic [N-1:0] ref_red(input logic [2*N-1:0] x, output bit sat);
    longint v, r, hi, lo;
    v  = longint'($signed(x));
    r  = (v + (longint'(1) << (F-1))) >>> F;
    hi = (longint'(1) << (N-1)) - 1;
    lo = -(longint'(1) << (N-1));
    sat = 1'b0;
    if (r > hi) begin r = hi; sat = 1'b1; end
    else if (r < lo) begin r = lo; sat = 1'b1; end
    return r[N-1:0];
  endfunction

  function automatic logic [2*N-1:0] rand_word();
    logic [63:0]        tmp;
    logic signed [40:0] mid;
    longint             b;
    tmp = {$urandom, $urandom};
    case ($urandom_range(0, 2))
      0: return tmp[2*N-1:0];
      1: begin
        mid = tmp[40:0];
        return w(longint'(mid));
      end
      default: begin
        b = ($urandom_range(0, 1) != 0) ? (longint'(1) << 39) : -(longint'(1) << 39);
        b = b + longint'($urandom_range(0, 65535)) - 32768;
        return w(b);
      end
    endcase
  endfunction

  // One clock: drive at negedge, observe 1ns later, score handshakes that fire at the next posedge.
  task automatic cycle(input logic v, input logic [2*N-1:0] x, input logic ordy, input logic clr);
    bit           s;
    logic [N-1:0] e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.ValorExt  = x;
    bus.out_ready = ordy;
    clr_stats     = clr;
    #1;
    obs_vld = bus.out_valid;
    obs_red = bus.ValorRed;
    obs_rdy = bus.in_ready;
    obs_acc = v && bus.in_ready;
    if (obs_acc) begin
      e = ref_red(x, s);
      exp_q.push_back(e);
      if (s) model_sat++;
    end
    if (obs_vld && ordy) begin
      if (exp_q.size() == 0) check("spurious_out", 64'(exp_q.size()), 64'd1);
      else check("stream_word", 64'(obs_red), 64'(exp_q.pop_front()));
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.ValorExt  = '0;
    bus.out_ready = 1'b0;
    clr_stats     = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    model_sat = 0;
  endtask

  initial begin
    logic [2*N-1:0] a, b, c, satw;
    logic           c_pending;

    tbl[0]  = '{w(longint'(1) << 30),                          25'h0008000, 16'd0, 1'b0};
    tbl[1]  = '{w(longint'(1) << 14),                          25'h0000001, 16'd0, 1'b0};
    tbl[2]  = '{w(-(longint'(1) << 14)),                       25'h0000000, 16'd0, 1'b0};
    tbl[3]  = '{w((longint'(1) << 14) - 1),                    25'h0000000, 16'd0, 1'b0};
    tbl[4]  = '{w(3 * (longint'(1) << 14)),                    25'h0000002, 16'd0, 1'b0};
    tbl[5]  = '{w(-3 * (longint'(1) << 14)),                   25'h1FFFFFF, 16'd0, 1'b0};
    tbl[6]  = '{w(-(longint'(1) << 14) - 1),                   25'h1FFFFFF, 16'd0, 1'b0};
    tbl[7]  = '{w((((longint'(1) << 24) - 1) << 15) + 16383),  25'h0FFFFFF, 16'd0, 1'b0};
    tbl[8]  = '{w(-(longint'(1) << 39) - 16384),               25'h1000000, 16'd0, 1'b0};
    tbl[9]  = '{w((longint'(1) << 49) - 1),                    MAX_POS,     16'd1, 1'b1};
    tbl[10] = '{w(-(longint'(1) << 49)),                       MIN_NEG,     16'd2, 1'b1};
    tbl[11] = '{w((((longint'(1) << 24) - 1) << 15) + 16384),  25'h0FFFFFF, 16'd3, 1'b1};
    tbl[12] = '{w(-(longint'(1) << 39) - 16385),               25'h1000000, 16'd4, 1'b1};

    // Reset state
    do_reset();
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_valor_red", 64'(unsigned'(bus.ValorRed)), 64'd0);
    check("rst_sat_flag",  64'(sat_flag), 64'd0);
    check("rst_sat_count", 64'(sat_count), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready), 64'd1);

    // Directed vectors, one word at a time, latency two cycles
    foreach (tbl[i]) begin
      cycle(1'b1, tbl[i].x, 1'b1, 1'b0);
      check("vec_accept", 64'(obs_acc), 64'd1);
      cycle(1'b0, '0, 1'b1, 1'b0);
      check("vec_not_early", 64'(obs_vld), 64'd0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      check("vec_valid", 64'(obs_vld), 64'd1);
      check("vec_value", 64'(obs_red), 64'(tbl[i].exp));
      check("vec_count", 64'(sat_count), 64'(tbl[i].cnt));
      check("vec_flag",  64'(sat_flag), 64'(tbl[i].flag));
    end
    drain();

    // Stall: out_ready low for 5 cycles while 3 words are offered
    do_reset();
    a = tbl[0].x; b = tbl[1].x; c = tbl[4].x;
    cycle(1'b1, a, 1'b0, 1'b0);
    check("stall_acc_a", 64'(obs_acc), 64'd1);
    cycle(1'b1, b, 1'b0, 1'b0);
    check("stall_acc_b", 64'(obs_acc), 64'd1);
    c_pending = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, c, 1'b0, 1'b0);
      if (obs_acc) c_pending = 1'b0;
      check("stall_in_ready", 64'(obs_rdy), 64'd0);
      check("stall_valid",    64'(obs_vld), 64'd1);
      check("stall_hold",     64'(obs_red), 64'h8000);
    end
    for (int i = 0; i < 10 && c_pending; i++) begin
      cycle(1'b1, c, 1'b1, 1'b0);
      if (obs_acc) c_pending = 1'b0;
    end
    check("stall_c_taken", 64'(c_pending), 64'd0);
    drain();

    // clr_stats coincident with a saturated S2 load
    do_reset();
    satw = tbl[9].x;
    cycle(1'b1, satw, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("clr_word",  64'(obs_red), 64'(MAX_POS));
    check("clr_count", 64'(sat_count), 64'd0);
    check("clr_flag",  64'(sat_flag), 64'd0);
    cycle(1'b1, satw, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("post_clr_count", 64'(sat_count), 64'd1);
    check("post_clr_flag",  64'(sat_flag), 64'd1);
    drain();

    // Sustained throughput with out_ready held high
    for (int i = 0; i < 50; i++) begin
      cycle(1'b1, rand_word(), 1'b1, 1'b0);
      check("tput_ready", 64'(obs_rdy), 64'd1);
      if (i >= 2) check("tput_valid", 64'(obs_vld), 64'd1);
    end
    drain();

    // Reset asserted mid-stream, away from a clock edge
    for (int i = 0; i < 6; i++) cycle(1'b1, rand_word(), 1'b1, 1'b0);
    check("pre_reset_valid", 64'(bus.out_valid), 64'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_out_valid", 64'(bus.out_valid), 64'd0);
    check("async_sat_count", 64'(sat_count), 64'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    model_sat = 0;
    #1;
    check("post_reset_ready", 64'(bus.in_ready), 64'd1);
    check("post_reset_valid", 64'(bus.out_valid), 64'd0);

    // Randomized stream with random back-pressure against the reference model
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 3) != 0), rand_word(), ($urandom_range(0, 3) != 0), 1'b0);
    end
    drain();
    check("rand_sat_count", 64'(sat_count), 64'(model_sat));
    check("rand_sat_flag",  64'(sat_flag), 64'(model_sat > 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reductor_saturado.md
REDUCTOR_SATURADO -- requirements
Module: reductor_saturado

Interface
REQ-001 SHALL have parameter N, default 25: output word width; input width is 2N.
REQ-002 SHALL have parameter F, default 15: fractional bits of output; input carries 2F fractional bits.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port ValorExt  input  2N  signed two's-complement wide value (Q with 2F fraction).
REQ-006 SHALL have port in_valid  input  1  ValorExt is valid this cycle.
REQ-007 SHALL have port in_ready  output  1  block accepts ValorExt this cycle.
REQ-008 SHALL have port ValorRed  output  N  signed rounded/saturated result (Q with F fraction).
REQ-009 SHALL have port out_valid  output  1  ValorRed is valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts ValorRed.
REQ-011 SHALL have port sat_flag  output  1  sticky: at least one saturated result delivered since reset/clear.
REQ-012 SHALL have port sat_count  output  16  number of saturated results delivered.
REQ-013 SHALL have port clr_stats  input  1  synchronous clear of sat_flag and sat_count.

Function
REQ-014 SHALL form a 2-stage pipeline: S1 registers input and rounded sum; S2 registers saturated result; latency 2 cycles from accept to out_valid with no stall.
REQ-015 SHALL use global enable en = !out_valid || out_ready; in_ready = en; both stages advance only when en=1.
REQ-016 SHALL accept a word only when in_valid && in_ready; S1 valid bit loads in_valid&&en.
REQ-017 SHALL hold ValorRed and out_valid stable while out_valid=1 and out_ready=0.
REQ-018 SHALL round half-up: sum = sign-extend(ValorExt, 2N+1) + 2^(F-1), computed in 2N+1 bits, no wrap.
REQ-019 SHALL take candidate = sum[2N:F] and deliver candidate[N-1:0] when all bits above N-1 equal candidate[N-1].
REQ-020 SHALL otherwise saturate: non-negative sum -> 2^(N-1)-1; negative sum -> -2^(N-1); sat bit travels with the word.
REQ-021 SHALL increment sat_count and set sat_flag when a saturated word loads S2 (en=1, S1 valid, sat=1); sat_count holds at 0xFFFF (no wrap).
REQ-022 SHALL give clr_stats precedence over a simultaneous increment: counter 0, flag 0 that cycle.
REQ-023 SHALL sustain one word per cycle with out_ready held high; no bubbles, no duplicates, no drops under any out_ready pattern.

Reset
REQ-024 SHALL on reset clear S1/S2 valid bits, out_valid=0, ValorRed=0, sat_flag=0, sat_count=0, independent of clk.
REQ-025 SHALL discard in-flight words on reset mid-operation; in_ready=1 immediately after reset deasserts.

Structure
REQ-026 SHALL place N, F defaults, MAX_POS/MIN_NEG constants and the rounding constant in a shared package/include used by Concatenador-side benches.
REQ-027 SHALL implement rounding+saturation as one combinational sub-module, redondeo_sat, instantiated between S1 and S2.

Verification (N=25, F=15)
REQ-028 SHALL test: ValorExt=2^30 (1.0), out_ready=1 -> ValorRed=0x0008000 two cycles later, sat_count=0.
REQ-029 SHALL test: ValorExt=2^14 -> 1; ValorExt=-2^14 -> 0; ValorExt=2^14-1 -> 0 (half-up rounding).
REQ-030 SHALL test: ValorExt=2^49-1 -> 0x0FFFFFF, sat_flag=1, sat_count=1; ValorExt=-2^49 -> 0x1000000, sat_count=2.
REQ-031 SHALL test: stream 5000 words read from ValoresSinExt.txt with random out_ready -> output sequence equals Concatenador round-trip model, order preserved, results written to Reducidos.txt.
REQ-032 SHALL test: out_ready=0 for 5 cycles with 3 words offered -> in_ready drops after pipeline fills, ValorRed stable, no loss on release.
REQ-033 SHALL test: clr_stats coincident with saturated S2 load -> sat_count=0, sat_flag=0; reset asserted mid-stream -> out_valid=0 asynchronously.
